// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program counter with exception PC and circular return-address stack
// Priority-ordered next-PC selection; RAS push overwrites the oldest entry when full.
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_4180),
  parameter int unsigned      RAS_DEPTH    = 4,
  localparam int unsigned     CW           = $clog2(RAS_DEPTH + 1),
  localparam int unsigned     PW           = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_addr,
  input  logic             call,
  input  logic             ret,
  input  logic             exception,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic [CW-1:0]    ras_count,
  output logic             ras_empty,
  output logic             ras_full
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_top;
  logic             push;

  function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] a);
    return {a[WIDTH-1:2], 2'b00};
  endfunction

  assign pc_plus4 = pc_q + WIDTH'(4);

  // ptr_q is the next write slot; the top of stack sits one below it
  assign ptr_inc = (ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : ptr_q + PW'(1);
  assign ptr_dec = (ptr_q == '0) ? PW'(RAS_DEPTH - 1) : ptr_q - PW'(1);
  assign ras_top = ras_q[ptr_dec];

  always_comb begin
    pc_d  = pc_plus4;
    epc_d = epc_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    push  = 1'b0;
    if (exception) begin
      epc_d = pc_q;
      pc_d  = EXC_VECTOR;
    end else if (eret) begin
      pc_d = align(epc_q);
    end else if (call) begin
      push  = 1'b1;
      ptr_d = ptr_inc;
      if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
      pc_d  = align(redirect_addr);
    end else if (ret) begin
      if (cnt_q != '0) begin
        pc_d  = align(ras_top);
        ptr_d = ptr_dec;
        cnt_d = cnt_q - CW'(1);
      end else begin
        pc_d = align(redirect_addr);
      end
    end else if (redirect) begin
      pc_d = align(redirect_addr);
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) ras_q[ptr_q] <= pc_plus4;
  end

  assign pc        = pc_q;
  assign epc       = epc_q;
  assign ras_count = cnt_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CW'(RAS_DEPTH));

endmodule
